// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI-style memory responder.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // log2 of bytes per beat for a full-width transfer
  function automatic int size_of_width(input int width);
    case (width)
      64:      return 3;
      128:     return 4;
      256:     return 5;
      default: return 2;
    endcase
  endfunction

endpackage

// File: rtl/axi_mem_lfsr16.sv
// 16-bit LFSR stall generator, only built when AXI_MEM_RESP_STALL_EN is defined.
// A stall is requested whenever bit 0 of the register is set.
`ifdef AXI_MEM_RESP_STALL_EN
module axi_mem_lfsr16 (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_stall
);

  logic [15:0] r_lfsr;

  // x^16 + x^14 + x^13 + x^11 + 1, maximal length
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign o_stall = r_lfsr[0];

endmodule
`endif

// File: rtl/axi_mem_responder.sv
// Single-transaction AXI-style slave memory with shared address channel.
// Optional handshake stalls are enabled with AXI_MEM_RESP_STALL_EN.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
  input  logic               axi_clk,
  input  logic               rst,
  input  logic [7:0]         aid,
  input  logic [31:0]        aaddr,
  input  logic [7:0]         alen,
  input  logic [2:0]         asize,
  input  logic [1:0]         aburst,
  input  logic [1:0]         alock,
  input  logic               atype,
  input  logic               avalid,
  output logic               aready,
  input  logic [7:0]         wid,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  output logic [7:0]         bid,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  output logic [7:0]         rid,
  output logic [WIDTH-1:0]   rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready
);

  localparam int          SZ      = size_of_width(WIDTH);
  localparam int          NB      = WIDTH / 8;
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  state_t      r_state;
  logic        r_aready, r_wready;
  logic        r_bvalid;
  logic [7:0]  r_bid;
  logic [1:0]  r_bresp;
  logic        r_rvalid, r_rlast;
  logic [7:0]  r_rid;
  logic [1:0]  r_rresp;
  logic [WIDTH-1:0] r_rdata;

  logic [7:0]  r_id, r_len;
  logic        r_fixed, r_err, r_below;
  logic [31:0] r_idx;
  logic [8:0]  r_cnt;

  // prefetch slot between the array read and the R output register
  logic             r_mrd_vld, r_mrd_oor, r_mrd_err, r_mrd_last;
  logic [WIDTH-1:0] r_mrd_data;

  logic          w_stall;
  logic          w_a_hs, w_w_hs, w_r_hs;
  logic          w_in_range, w_last_beat, w_wbeat_err, w_f_err;
  logic          w_fetch_more, w_a_load, w_b_load;
  logic [31:0]   w_off;
  logic [AW-1:0] w_mem_idx;
  logic          w_unused;

`ifdef AXI_MEM_RESP_STALL_EN
  axi_mem_lfsr16 u_lfsr (
    .i_clk   (axi_clk),
    .i_rst   (rst),
    .o_stall (w_stall)
  );
`else
  assign w_stall = 1'b0;
`endif

  assign w_unused = ^{alock, wid};

  assign aready = r_aready & ~w_stall;
  assign wready = r_wready & ~w_stall;
  assign bvalid = r_bvalid;
  assign bid    = r_bid;
  assign bresp  = r_bresp;
  assign rvalid = r_rvalid;
  assign rid    = r_rid;
  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign rlast  = r_rlast;

  assign w_a_hs = avalid & aready;
  assign w_w_hs = wvalid & wready;
  assign w_r_hs = r_rvalid & rready;

  assign w_off       = aaddr - BASE_ADDR;
  assign w_mem_idx   = r_idx[AW-1:0];
  assign w_in_range  = !r_below && (r_idx < DEPTH_W);
  assign w_last_beat = (r_cnt == {1'b0, r_len});
  assign w_wbeat_err = !w_in_range || (wlast != w_last_beat);
  assign w_f_err     = r_err | !w_in_range;

  // Output register refills from the prefetch slot when empty or being drained;
  // the slot refills in the same cycle, giving one beat per clock.
  assign w_fetch_more = (r_state == RDATA) && (r_cnt <= {1'b0, r_len});
  assign w_b_load     = r_mrd_vld && (!r_rvalid || rready) && !w_stall;
  assign w_a_load     = w_fetch_more && (!r_mrd_vld || w_b_load);

  always_ff @(posedge axi_clk) begin
    if (w_w_hs && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) r_mem[w_mem_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (w_a_load) r_mrd_data <= r_mem[w_mem_idx];
  end

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_aready   <= 1'b1;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
      r_id       <= '0;
      r_len      <= '0;
      r_fixed    <= 1'b0;
      r_err      <= 1'b0;
      r_below    <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_mrd_vld  <= 1'b0;
      r_mrd_oor  <= 1'b0;
      r_mrd_err  <= 1'b0;
      r_mrd_last <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_a_hs) begin
            r_aready <= 1'b0;
            r_id     <= aid;
            r_len    <= alen;
            r_fixed  <= (aburst == BURST_FIXED);
            r_err    <= ((aburst != BURST_FIXED) && (aburst != BURST_INCR)) ||
                        (asize != 3'(SZ));
            r_below  <= (aaddr < BASE_ADDR);
            r_idx    <= w_off >> SZ;
            r_cnt    <= '0;
            r_wready <= atype;
            r_state  <= atype ? WDATA : RDATA;
          end
        end

        WDATA: begin
          if (w_w_hs) begin
            r_cnt <= r_cnt + 9'd1;
            r_err <= r_err | w_wbeat_err;
            if (!r_fixed) r_idx <= r_idx + 32'd1;
            if (w_last_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (r_err | w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
              r_state  <= WRESP;
            end
          end
        end

        WRESP: begin
          if (bready) begin
            r_bvalid <= 1'b0;
            r_aready <= 1'b1;
            r_state  <= IDLE;
          end
        end

        RDATA: begin
          if (w_a_load) begin
            r_mrd_vld  <= 1'b1;
            r_mrd_oor  <= !w_in_range;
            r_mrd_err  <= w_f_err;
            r_mrd_last <= w_last_beat;
            r_err      <= w_f_err;
            r_cnt      <= r_cnt + 9'd1;
            if (!r_fixed) r_idx <= r_idx + 32'd1;
          end else if (w_b_load) begin
            r_mrd_vld <= 1'b0;
          end

          if (w_b_load) begin
            r_rvalid <= 1'b1;
            r_rid    <= r_id;
            r_rdata  <= r_mrd_oor ? '0 : r_mrd_data;
            r_rresp  <= r_mrd_err ? RESP_SLVERR : RESP_OKAY;
            r_rlast  <= r_mrd_last;
          end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
          end

          if (w_r_hs && r_rlast) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_aready <= 1'b1;
            r_state  <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: a word-array reference model queues
// expected B/R responses, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_axi_mem_responder;

  localparam int          D    = 1024;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          LIM  = 2000;

  logic        axi_clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aid = '0;
  logic [31:0] aaddr = '0;
  logic [7:0]  alen = '0;
  logic [2:0]  asize = 3'd2;
  logic [1:0]  aburst = 2'b01;
  logic [1:0]  alock = '0;
  logic        atype = 1'b0;
  logic        avalid = 1'b0;
  logic        aready;
  logic [7:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 axi_clk = ~axi_clk;

  axi_mem_responder #(.WIDTH(32), .DEPTH(D), .BASE_ADDR(BASE)) dut (
    .axi_clk(axi_clk), .rst(rst),
    .aid(aid), .aaddr(aaddr), .alen(alen), .asize(asize), .aburst(aburst),
    .alock(alock), .atype(atype), .avalid(avalid), .aready(aready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  logic [31:0] m_mem [D];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: no handshake within %0d cycles, expected one", name, LIM);
  endtask

  // ---------------- reference model ----------------
  function automatic longint beat_idx(input logic [31:0] addr, input int b, input logic [1:0] burst);
    longint i;
    if (addr < BASE) return -1;
    i = longint'((addr - BASE) >> 2) + ((burst == 2'b00) ? 0 : b);
    return (i >= D) ? -1 : i;
  endfunction

  task automatic model_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int wl);
    bit err;
    longint i;
    b_exp_t e;
    err = (burst > 2'b01) || (size != 3'd2);
    for (int b = 0; b <= int'(len); b++) begin
      i = beat_idx(addr, b, burst);
      if (i < 0) err = 1;
      else for (int k = 0; k < 4; k++) if (sbuf[b][k]) m_mem[i][8*k +: 8] = wbuf[b][8*k +: 8];
      if ((b == wl) != (b == int'(len))) err = 1;
    end
    e.id = id;
    e.resp = err ? 2'b10 : 2'b00;
    bq.push_back(e);
  endtask

  task automatic model_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
    bit err;
    longint i;
    r_exp_t e;
    err = (burst > 2'b01) || (size != 3'd2);
    for (int b = 0; b <= int'(len); b++) begin
      i = beat_idx(addr, b, burst);
      if (i < 0) err = 1;
      e.id   = id;
      e.data = (i < 0) ? 32'h0 : m_mem[i];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (b == int'(len));
      rq.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  logic       pb_v = 1'b0, pr_v = 1'b0;
  logic [7:0] pb_id, pr_id;
  logic [1:0] pb_resp, pr_resp;
  logic [31:0] pr_data;
  logic       pr_last;
  b_exp_t     mb;
  r_exp_t     mr;

  always @(negedge axi_clk) begin
    if (rst) begin
      pb_v = 1'b0;
      pr_v = 1'b0;
    end else begin
      if (pb_v) begin
        chk("b_hold_valid", bvalid, 1);
        chk("b_hold_id", bid, pb_id);
        chk("b_hold_resp", bresp, pb_resp);
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL b_extra: got bid %0h, expected no response", bid);
        end else begin
          mb = bq.pop_front();
          chk("bid", bid, mb.id);
          chk("bresp", bresp, mb.resp);
        end
      end
      pb_v = bvalid && !bready; pb_id = bid; pb_resp = bresp;

      if (pr_v) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, pr_data);
        chk("r_hold_last", rlast, pr_last);
        chk("r_hold_resp", rresp, pr_resp);
        chk("r_hold_id", rid, pr_id);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL r_extra: got rdata %0h, expected no beat", rdata);
        end else begin
          mr = rq.pop_front();
          chk("rid", rid, mr.id);
          chk("rdata", rdata, mr.data);
          chk("rresp", rresp, mr.resp);
          chk("rlast", rlast, mr.last);
        end
      end
      pr_v = rvalid && !rready; pr_id = rid; pr_data = rdata; pr_resp = rresp; pr_last = rlast;
    end
  end

  // ---------------- drivers ----------------
  task automatic addr_phase(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic typ);
    int n;
    aid = id; aaddr = addr; alen = len; aburst = burst; asize = size; atype = typ;
    alock = 2'($urandom); avalid = 1'b1;
    n = 0;
    do begin @(negedge axi_clk); n++; end while (!aready && n < LIM);
    if (!aready) timeout("a_handshake");
    @(posedge axi_clk); #1;
    avalid = 1'b0; aid = 8'($urandom); aaddr = $urandom; alen = 8'($urandom);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int wl,
                          input int bdelay, input bit gaps);
    int n;
    model_write(id, addr, len, burst, size, wl);
    addr_phase(id, addr, len, burst, size, 1'b1);
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps) begin
        n = 0;
        while ($urandom_range(0, 3) == 0 && n < 4) begin
          wvalid = 1'b0; n++;
          @(posedge axi_clk); #1;
        end
      end
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == wl); wid = 8'($urandom);
      n = 0;
      do begin @(negedge axi_clk); n++; end while (!wready && n < LIM);
      if (!wready) timeout("w_handshake");
      @(posedge axi_clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat (bdelay) begin @(posedge axi_clk); #1; end
    bready = 1'b1;
    n = 0;
    do begin @(negedge axi_clk); n++; end while (!bvalid && n < LIM);
    if (!bvalid) timeout("b_handshake");
    @(posedge axi_clk); #1;
    bready = 1'b0;
  endtask

  // mode 0: rready held high, 1: toggled every cycle, 2: random
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int mode,
                         input bit chk_lat, input bit chk_tput);
    int got, c, first, f_hs, l_hs;
    model_read(id, addr, len, burst, size);
    addr_phase(id, addr, len, burst, size, 1'b0);
    got = 0; c = 0; first = -1; f_hs = -1; l_hs = -1;
    rready = (mode == 1) ? 1'b0 : 1'b1;
    while (got <= int'(len) && c < LIM) begin
      @(negedge axi_clk); c++;
      if (rvalid && first < 0) first = c;
      if (rvalid && rready) begin
        if (f_hs < 0) f_hs = c;
        l_hs = c; got++;
      end
      @(posedge axi_clk); #1;
      case (mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
    end
    rready = 1'b0;
    if (got <= int'(len)) timeout("r_burst");
    if (chk_lat)  chk("r_first_latency", 64'(first), 64'd3);
    if (chk_tput) chk("r_burst_cycles", 64'(l_hs - f_hs), 64'(len));
  endtask

  task automatic fill_buf(input int n, input logic [3:0] strb, input bit random_data);
    for (int b = 0; b < n; b++) begin
      wbuf[b] = random_data ? $urandom : 32'(b);
      sbuf[b] = strb;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  t_id, t_len;
    logic [31:0] t_addr;
    logic [1:0]  t_burst;
    logic [2:0]  t_size;
    int          r, wl;

    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("rst_aready", aready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rlast", rlast, 0);
    @(posedge axi_clk); #1;
    rst = 1'b0;

    // initialise the whole array so every later read has a known model value
    for (int q = 0; q < 4; q++) begin
      fill_buf(256, 4'hF, 1);
      do_write(8'(q), 32'(q * 1024), 8'd255, 2'b01, 3'd2, 255, 0, 0);
    end

    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(8'h5A, 32'h0, 8'd0, 2'b01, 3'd2, 0, 0, 0);
    do_read(8'h5A, 32'h0, 8'd0, 2'b01, 3'd2, 0, 1, 0);

    fill_buf(70, 4'hF, 0);
    do_write(8'h11, 32'h118, 8'd69, 2'b01, 3'd2, 69, 0, 0);
    do_read(8'h12, 32'h118, 8'd69, 2'b01, 3'd2, 0, 1, 1);

    fill_buf(8, 4'hF, 1);
    do_write(8'h21, 32'h400, 8'd7, 2'b01, 3'd2, 7, 5, 1);
    do_read(8'h22, 32'h400, 8'd7, 2'b01, 3'd2, 1, 0, 0);

    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
    do_write(8'h31, 32'h40, 8'd0, 2'b01, 3'd2, 0, 0, 0);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
    do_write(8'h32, 32'h40, 8'd0, 2'b01, 3'd2, 0, 0, 0);
    do_read(8'h33, 32'h40, 8'd0, 2'b01, 3'd2, 0, 0, 0);

    wbuf[0] = 32'hA5A5_0001; wbuf[1] = 32'hA5A5_0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(8'h41, 32'((D - 1) * 4), 8'd1, 2'b01, 3'd2, 1, 0, 0);
    do_read(8'h42, 32'((D - 1) * 4), 8'd0, 2'b01, 3'd2, 0, 0, 0);
    do_read(8'h43, 32'((D - 1) * 4), 8'd1, 2'b01, 3'd2, 0, 0, 0);
    do_read(8'h44, 32'h0, 8'd1, 2'b01, 3'd2, 2, 0, 0);

    fill_buf(4, 4'hF, 1);
    do_write(8'h51, 32'h300, 8'd3, 2'b01, 3'd2, 2, 0, 0);

    // reset in the middle of a read burst
    model_read(8'h52, 32'h200, 8'd7, 2'b01, 3'd2);
    addr_phase(8'h52, 32'h200, 8'd7, 2'b01, 3'd2, 1'b0);
    rready = 1'b1;
    repeat (4) @(posedge axi_clk);
    #1;
    rready = 1'b0;
    rst = 1'b1;
    @(negedge axi_clk);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_aready", aready, 1);
    chk("midrst_rlast", rlast, 0);
    @(posedge axi_clk); #1;
    rst = 1'b0;
    rq.delete();
    @(negedge axi_clk);
    chk("postrst_rvalid", rvalid, 0);
    chk("postrst_aready", aready, 1);
    @(posedge axi_clk); #1;

    fill_buf(3, 4'hF, 1);
    do_write(8'h61, 32'h280, 8'd2, 2'b01, 3'd2, 2, 1, 0);
    do_read(8'h62, 32'h280, 8'd2, 2'b01, 3'd2, 2, 0, 0);

    for (int t = 0; t < 40; t++) begin
      t_id   = 8'($urandom);
      t_len  = 8'($urandom_range(0, 15));
      t_addr = 32'($urandom_range(0, 1040 * 4));
      r      = $urandom_range(0, 9);
      t_burst = (r < 2) ? 2'b00 : (r < 9) ? 2'b01 : 2'($urandom_range(2, 3));
      t_size  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 16; b++) begin
          wbuf[b] = $urandom;
          sbuf[b] = 4'($urandom);
        end
        wl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(t_len)) : int'(t_len);
        do_write(t_id, t_addr, t_len, t_burst, t_size, wl, $urandom_range(0, 3), 1);
      end else begin
        do_read(t_id, t_addr, t_len, t_burst, t_size, 2, 0, 0);
      end
    end

    repeat (4) @(posedge axi_clk);
    chk("b_queue_left", 64'(bq.size()), 64'd0);
    chk("r_queue_left", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI-style slave memory model answering the team's single-channel AXI initiators: one shared address channel with `atype` (1 = write, 0 = read), plus W, B and R channels.
- Stores write bursts in an internal word array and returns them on read bursts with the matching ID.
- Used as the DDR stand-in for simulation and as an on-chip scratch target in the video-process designs.
- Serves one transaction at a time; no outstanding-transaction queue.

Parameters:
- `WIDTH`, 32, data width in bits (32/64/128/256).
- `DEPTH`, 1024, number of `WIDTH`-bit words in the array.
- `BASE_ADDR`, 32'h00000000, byte address mapped to word 0.

Ports:
- `axi_clk`  in  1  sole clock
- `rst`  in  1  asynchronous reset, active-high
- `aid`  in  8  transaction ID
- `aaddr`  in  32  byte start address
- `alen`  in  8  beats minus 1
- `asize`  in  3  log2 bytes per beat
- `aburst`  in  2  00 FIXED, 01 INCR, others illegal
- `alock`  in  2  ignored
- `atype`  in  1  1 write, 0 read
- `avalid`  in  1  address valid
- `aready`  out  1  address accepted
- `wid`  in  8  ignored
- `wdata`  in  `WIDTH`  write data
- `wstrb`  in  `WIDTH`/8  byte enables
- `wlast`  in  1  last write beat
- `wvalid`  in  1  write data valid
- `wready`  out  1  write data accepted
- `bid`  out  8  response ID
- `bresp`  out  2  write response
- `bvalid`  out  1  write response valid
- `bready`  in  1  response accepted
- `rid`  out  8  read ID
- `rdata`  out  `WIDTH`  read data
- `rresp`  out  2  read response
- `rlast`  out  1  last read beat
- `rvalid`  out  1  read data valid
- `rready`  in  1  read data accepted

Behaviour:
- Reset values: all outputs 0, except `aready` = 1. State = IDLE. Array contents are not reset.
- State IDLE:
  - `aready` = 1.
  - On `avalid & aready`, capture `aid`, `aaddr`, `alen`, `aburst`, `atype`; set beat counter = 0; drop `aready` on the next edge.
  - Go to WDATA (`atype` = 1) or RDATA (`atype` = 0).
- Word index = (`aaddr` - `BASE_ADDR`) >> log2(`WIDTH`/8).
  - INCR: index +1 per beat.
  - FIXED: index held.
  - Illegal `aburst`: treated as INCR with response forced to SLVERR.
  - `asize` other than full width: response SLVERR, data path still full width.
- Out of range (index >= `DEPTH`, or address below `BASE_ADDR`): that beat's write is dropped, read data = 0, response sticky SLVERR (2'b10) for the burst. Index does not wrap.
- State WDATA:
  - `wready` = 1.
  - Each `wvalid & wready` writes the addressed word byte-wise per `wstrb` and increments the counter.
  - `wlast` must be high exactly on beat `alen`; mismatch sets SLVERR.
  - The burst ends on beat `alen` regardless of `wlast`; any extra beats wait for the next transaction.
  - Then `wready` = 0 → WRESP.
- State WRESP:
  - `bvalid` = 1, `bid` = captured ID, `bresp` = 00 or 10.
  - Held stable until `bready`; on `bvalid & bready` → IDLE, `aready` = 1 on the next cycle.
- State RDATA:
  - Synchronous array read; first `rvalid` on the 2nd edge after the address handshake.
  - `rid` = captured ID; `rlast` = 1 on beat `alen`.
  - While `rvalid & !rready`: `rdata`/`rresp`/`rlast` held stable.
  - On `rvalid & rready`: the next beat is presented on the following edge. Data is prefetched, giving 1 beat/cycle under continuous `rready`.
  - After the `rlast` handshake → IDLE.
- Read-after-write: the read of a just-written word returns the new data (the write completes before the B handshake).
- `alen` = 0: single beat, `rlast`/`wlast` on beat 0.
- Maximum `alen` = 255; counter is 9 bits.
- `rst` mid-burst: immediate return to IDLE with outputs at reset values. Partially written words remain in the array.

Optional Feature:
- `AXI_MEM_RESP_STALL_EN`
  - Defined: a 16-bit LFSR (seed 16'hACE1, reset by `rst`) gates `aready`, `wready` and `rvalid` presentation; a stall is inserted when LFSR[0] = 1. Once asserted, `rvalid` is never withdrawn before its handshake.
  - Undefined: no stalls, timing exactly as above.

Decomposition:
- Package `axi_mem_pkg`:
  - State enum IDLE/WDATA/WRESP/RDATA.
  - Response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Burst constants BURST_FIXED, BURST_INCR.
  - Function `size_of_width(WIDTH)` returning 2/3/4/5.
- Sub-module `axi_mem_lfsr16`: stall generator, instantiated only under `AXI_MEM_RESP_STALL_EN`.

Test Plan:
- Write `aid` = 8'h5A, `aaddr` = 0, `alen` = 0, `wdata` = 32'hDEADBEEF; then read the same → `bresp` = 00, `bid` = 5A; one R beat `rdata` = DEADBEEF, `rlast` = 1, `rid` = 5A.
- INCR write `alen` = 69 at 0x118, data = beat index; read back with `rready` held 1 → 70 beats in 70 consecutive cycles after the first, `rlast` only on beat 69, all data match.
- `bready` held low 5 cycles, `rready` toggled every other cycle → `bvalid`/`bid` and `rdata`/`rlast` stable while stalled; no beats lost or duplicated.
- Write with `wstrb` = 4'b0101, `wdata` = 32'h11223344 over a word holding FFFFFFFF → readback FF22FF44.
- Write to index `DEPTH`-1, `alen` = 1 → `bresp` = 10; readback of `DEPTH`-1 returns the beat-0 data; a read of the same burst gives beat 1 `rdata` = 0, `rresp` = 10.
- `wlast` asserted on beat 2 of an `alen` = 3 burst → `bresp` = 10. Then `rst` pulsed mid read burst → `rvalid` = 0 and `aready` = 1 next cycle, and a following transaction completes with OKAY.
